// File: rtl/clv_rle_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : clv_rle_decoder                                              |
// | Description : Code-length-vector run-length decoder for DEFLATE dynamic    |
// |               block headers. Expands code-length-alphabet symbols 0..18    |
// |               (with their extra-bit values) into one 4-bit code length per |
// |               output symbol, written sequentially into a length RAM.       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
// | Parameters                                                                 |
// |   MAX_SYMS   largest legal vector length (286 lit/len + 30 dist)           |
// |   ADDR_W     width of wr_addr_o / num_syms_i; 2**ADDR_W >= MAX_SYMS        |
// | Ports                                                                      |
// |   clk_i        clock, all state on rising edge                             |
// |   reset_i      asynchronous active-high reset                              |
// |   start_i      1-cycle pulse: latch num_syms_i, clear state, begin decode  |
// |   num_syms_i   number of lengths to produce                                |
// |   in_valid_i   symbol/extra pair valid                                     |
// |   in_ready_o   pair accepted when in_valid_i && in_ready_o                 |
// |   in_sym_i     code-length symbol 0..18                                    |
// |   in_extra_i   extra-bit value (16: 2b, 17: 3b, 18: 7b)                    |
// |   wr_en_o      registered length write strobe                              |
// |   wr_addr_o    registered symbol index                                     |
// |   wr_data_o    registered code length                                      |
// |   done_o       high from completion until next start                       |
// |   error_o      sticky fault flag until next start                          |
// |   bl_count_o   per-length write counts, length n at [n*ADDR_W +: ADDR_W]   |
// | Configuration                                                              |
// |   CLV_BL_COUNT_EN  when defined, bl_count_o counts writes per length and   |
// |                    clears on start; otherwise bl_count_o is tied to zero.  |
// +----------------------------------------------------------------------------+
module clv_rle_decoder #(
  parameter int MAX_SYMS = 316,
  parameter int ADDR_W   = 9
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic [ADDR_W-1:0]    num_syms_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [4:0]           in_sym_i,
  input  logic [6:0]           in_extra_i,
  output logic                 wr_en_o,
  output logic [ADDR_W-1:0]    wr_addr_o,
  output logic [3:0]           wr_data_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic [16*ADDR_W-1:0] bl_count_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEPT = 3'd1,
    S_REPEAT = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  // Wide enough to hold count + longest run without wrapping.
  localparam int SUM_W = ADDR_W + 2;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic [ADDR_W-1:0]   num_q, num_d;
  logic [3:0]          prev_len_q, prev_len_d;
  logic                have_prev_q, have_prev_d;
  logic [7:0]          run_left_q, run_left_d;
  logic [3:0]          run_val_q, run_val_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [3:0]          wr_data_q, wr_data_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic [7:0]          w_run;
  logic [3:0]          w_run_val;
  logic                w_is_lit;
  logic                w_bad_sym;
  logic                w_no_prev;
  logic [SUM_W-1:0]    w_run_end;
  logic                w_overrun;
  logic                w_num_bad;
  logic [ADDR_W-1:0]   w_count_inc;
  logic                w_accept;

  // --------------------------------------------------------------------------
  // Symbol decode for the pair currently presented
  // --------------------------------------------------------------------------
  always_comb begin
    w_run = 8'd0;
    case (in_sym_i)
      5'd16:   w_run = 8'd3  + {6'd0, in_extra_i[1:0]};
      5'd17:   w_run = 8'd3  + {5'd0, in_extra_i[2:0]};
      5'd18:   w_run = 8'd11 + {1'b0, in_extra_i};
      default: w_run = 8'd0;
    endcase
  end

  assign w_is_lit    = (in_sym_i < 5'd16);
  assign w_bad_sym   = (in_sym_i > 5'd18);
  // Sym 16 copies the previous length; 17/18 are zero runs.
  assign w_run_val   = (in_sym_i == 5'd16) ? prev_len_q : 4'd0;
  assign w_no_prev   = (in_sym_i == 5'd16) && !have_prev_q;
  // Overrun is judged against the whole run before any of it is written.
  assign w_run_end   = SUM_W'(count_q) + SUM_W'(w_run);
  assign w_overrun   = (w_run_end > SUM_W'(num_q));
  assign w_num_bad   = (num_syms_i == '0) || (32'(num_syms_i) > 32'(MAX_SYMS));
  assign w_count_inc = count_q + ADDR_W'(1);

  assign in_ready_o  = (state_q == S_ACCEPT) && (count_q < num_q);
  assign w_accept    = in_valid_i && in_ready_o;

  // --------------------------------------------------------------------------
  // Next-state and write generation
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    num_d       = num_q;
    prev_len_d  = prev_len_q;
    have_prev_d = have_prev_q;
    run_left_d  = run_left_q;
    run_val_d   = run_val_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    done_d      = done_q;
    error_d     = error_q;

    if (start_i) begin
      // Start wins over everything, including an in-flight run: the old
      // vector is dropped and no further write from it is issued.
      num_d       = num_syms_i;
      count_d     = '0;
      prev_len_d  = 4'd0;
      have_prev_d = 1'b0;
      run_left_d  = 8'd0;
      run_val_d   = 4'd0;
      done_d      = 1'b0;
      if (w_num_bad) begin
        state_d = S_ERR;
        error_d = 1'b1;
      end else begin
        state_d = S_ACCEPT;
        error_d = 1'b0;
      end
    end else begin
      case (state_q)
        S_ACCEPT: begin
          if (count_q == num_q) begin
            // Final write went out last cycle; completion shows one later.
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (w_accept) begin
            if (w_bad_sym) begin
              state_d = S_ERR;
              error_d = 1'b1;
            end else if (w_is_lit) begin
              wr_en_d     = 1'b1;
              wr_addr_d   = count_q;
              wr_data_d   = in_sym_i[3:0];
              count_d     = w_count_inc;
              prev_len_d  = in_sym_i[3:0];
              have_prev_d = 1'b1;
            end else if (w_no_prev || w_overrun) begin
              state_d = S_ERR;
              error_d = 1'b1;
            end else begin
              // First element of the run is written on the accept edge;
              // the rest follow one per cycle from S_REPEAT.
              wr_en_d     = 1'b1;
              wr_addr_d   = count_q;
              wr_data_d   = w_run_val;
              count_d     = w_count_inc;
              run_left_d  = w_run - 8'd1;
              run_val_d   = w_run_val;
              prev_len_d  = w_run_val;
              have_prev_d = 1'b1;
              state_d     = S_REPEAT;
            end
          end
        end

        S_REPEAT: begin
          if (run_left_q != 8'd0) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = count_q;
            wr_data_d  = run_val_q;
            count_d    = w_count_inc;
            run_left_d = run_left_q - 8'd1;
          end else if (count_q == num_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ACCEPT;
          end
        end

        S_IDLE, S_DONE, S_ERR: begin
          state_d = state_q;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      num_q       <= '0;
      prev_len_q  <= 4'd0;
      have_prev_q <= 1'b0;
      run_left_q  <= 8'd0;
      run_val_q   <= 4'd0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 4'd0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      num_q       <= num_d;
      prev_len_q  <= prev_len_d;
      have_prev_q <= have_prev_d;
      run_left_q  <= run_left_d;
      run_val_q   <= run_val_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign done_o    = done_q;
  assign error_o   = error_q;

  // --------------------------------------------------------------------------
  // Per-length histogram for the canonical-code builder
  // --------------------------------------------------------------------------
`ifdef CLV_BL_COUNT_EN
  for (genvar n = 0; n < 16; n++) begin : g_bl_count
    logic [ADDR_W-1:0] cnt_q;

    // Counts track the write strobe issued on the same edge, so they are
    // complete by the time done_o rises.
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        cnt_q <= '0;
      end else if (start_i) begin
        cnt_q <= '0;
      end else if (wr_en_d && (wr_data_d == 4'(n))) begin
        cnt_q <= cnt_q + ADDR_W'(1);
      end
    end

    assign bl_count_o[n*ADDR_W +: ADDR_W] = cnt_q;
  end
`else
  assign bl_count_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clv_rle_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_clv_rle_decoder                                           |
// | Description : Self-checking bench for clv_rle_decoder. Directed vectors    |
// |               plus random symbol streams, compared against a list-based    |
// |               expansion model of the code-length run-length rules.         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_clv_rle_decoder;

  localparam int ADDR_W   = 9;
  localparam int MAX_SYMS = 316;

  logic                 clk = 1'b0;
  logic                 reset_i;
  logic                 start_i;
  logic [ADDR_W-1:0]    num_syms_i;
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [4:0]           in_sym_i;
  logic [6:0]           in_extra_i;
  logic                 wr_en_o;
  logic [ADDR_W-1:0]    wr_addr_o;
  logic [3:0]           wr_data_o;
  logic                 done_o;
  logic                 error_o;
  logic [16*ADDR_W-1:0] bl_count_o;

  int checks = 0;
  int errors = 0;

  // Stimulus pairs and model expectations
  int p_sym[$];
  int p_ext[$];
  int exp_len[$];
  bit exp_err;
  bit exp_done;

  // Observed writes
  int obs_addr[$];
  int obs_data[$];
  int cyc         = 0;
  int last_wr_cyc = 0;
  int done_cyc    = 0;
  bit done_seen   = 1'b0;

  clv_rle_decoder #(.MAX_SYMS(MAX_SYMS), .ADDR_W(ADDR_W)) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .start_i    (start_i),
    .num_syms_i (num_syms_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_sym_i   (in_sym_i),
    .in_extra_i (in_extra_i),
    .wr_en_o    (wr_en_o),
    .wr_addr_o  (wr_addr_o),
    .wr_data_o  (wr_data_o),
    .done_o     (done_o),
    .error_o    (error_o),
    .bl_count_o (bl_count_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (wr_en_o) begin
      obs_addr.push_back(int'(wr_addr_o));
      obs_data.push_back(int'(wr_data_o));
      last_wr_cyc = cyc;
    end
    if (done_o && !done_seen) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expand the pair list by the run-length rules into the list of lengths
  // that should be written, stopping at the first fault or when full.
  function automatic void run_model(input int num);
    int prev;
    int s, e, run, v;
    exp_len.delete();
    exp_err = 1'b0;
    prev    = -1;
    if (num < 1 || num > MAX_SYMS) begin
      exp_err = 1'b1;
    end else begin
      for (int i = 0; i < p_sym.size(); i++) begin
        if (exp_err || exp_len.size() == num) break;
        s = p_sym[i];
        e = p_ext[i];
        if (s > 18) begin
          exp_err = 1'b1;
        end else if (s < 16) begin
          exp_len.push_back(s);
          prev = s;
        end else begin
          run = (s == 16) ? 3 + (e % 4) : (s == 17) ? 3 + (e % 8) : 11 + (e % 128);
          v   = (s == 16) ? prev : 0;
          if (s == 16 && prev < 0) exp_err = 1'b1;
          else if (exp_len.size() + run > num) exp_err = 1'b1;
          else begin
            for (int k = 0; k < run; k++) exp_len.push_back(v);
            prev = v;
          end
        end
      end
    end
    exp_done = !exp_err && (exp_len.size() == num);
  endfunction

  function automatic logic [16*ADDR_W-1:0] exp_bl();
    logic [16*ADDR_W-1:0] v = '0;
`ifdef CLV_BL_COUNT_EN
    int h[16];
    for (int k = 0; k < 16; k++) h[k] = 0;
    foreach (exp_len[i]) h[exp_len[i]]++;
    for (int k = 0; k < 16; k++) v[k*ADDR_W +: ADDR_W] = ADDR_W'(h[k]);
`endif
    return v;
  endfunction

  task automatic clear_pairs();
    p_sym.delete();
    p_ext.delete();
  endtask

  task automatic add(input int s, input int e);
    p_sym.push_back(s);
    p_ext.push_back(e);
  endtask

  // Random stream that ends as soon as the model reaches completion or a fault.
  task automatic gen(input int num);
    int s, e, r, rem, base, mask;
    clear_pairs();
    for (int n = 0; n < 400; n++) begin
      run_model(num);
      if (exp_err || exp_done) break;
      rem = num - exp_len.size();
      r   = int'($urandom_range(0, 99));
      e   = int'($urandom_range(0, 127));
      if (r < 2) begin
        s = int'($urandom_range(19, 31));
      end else if (r < 70) begin
        s = int'($urandom_range(0, 15));
      end else begin
        s    = int'($urandom_range(16, 18));
        base = (s == 18) ? 11 : 3;
        mask = (s == 16) ? 3 : (s == 17) ? 7 : 127;
        if ($urandom_range(0, 9) != 0 && base + (e & mask) > rem && rem >= base)
          e = rem - base;
      end
      add(s, e);
    end
    run_model(num);
  endtask

  task automatic do_start(input int num);
    @(posedge clk); #1;
    start_i    = 1'b1;
    num_syms_i = ADDR_W'(num);
    in_valid_i = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b0;
    obs_addr.delete();
    obs_data.delete();
    done_seen   = 1'b0;
    last_wr_cyc = 0;
    done_cyc    = 0;
  endtask

  task automatic send_pair(input int s, input int e);
    in_sym_i   = 5'(s);
    in_extra_i = 7'(e);
    in_valid_i = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (in_ready_o) begin
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        return;
      end
      if (error_o || done_o) begin
        in_valid_i = 1'b0;
        return;
      end
    end
    in_valid_i = 1'b0;
    checks++;
    errors++;
    $error("FAIL send_timeout observed=in_ready_low required=in_ready_high sym=%0d", s);
  endtask

  task automatic feed_all();
    for (int i = 0; i < p_sym.size(); i++) begin
      if (error_o || done_o) break;
      send_pair(p_sym[i], p_ext[i]);
    end
  endtask

  task automatic end_vec(input string tag);
    int mism;
    int n;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (done_o || error_o) break;
    end
    repeat (2) @(negedge clk);
    check({tag, ".nwr"}, obs_addr.size(), exp_len.size());
    mism = 0;
    n = (obs_addr.size() < exp_len.size()) ? obs_addr.size() : exp_len.size();
    for (int i = 0; i < n; i++)
      if (obs_addr[i] != i || obs_data[i] != exp_len[i]) mism++;
    check({tag, ".wrseq"}, mism, 0);
    check({tag, ".error"}, error_o, exp_err);
    check({tag, ".done"}, done_o, exp_done);
    if (exp_done) check({tag, ".donelat"}, done_cyc - last_wr_cyc, 1);
    check({tag, ".blcount"}, bl_count_o, exp_bl());
  endtask

  task automatic run_vec(input string tag, input int num);
    run_model(num);
    do_start(num);
    feed_all();
    end_vec(tag);
  endtask

  initial begin
    int ok;
    int num;
    reset_i    = 1'b1;
    start_i    = 1'b0;
    in_valid_i = 1'b0;
    num_syms_i = '0;
    in_sym_i   = '0;
    in_extra_i = '0;

    repeat (3) @(negedge clk);
    check("rst.in_ready", in_ready_o, 0);
    check("rst.wr_en",    wr_en_o, 0);
    check("rst.wr_addr",  wr_addr_o, 0);
    check("rst.wr_data",  wr_data_o, 0);
    check("rst.done",     done_o, 0);
    check("rst.error",    error_o, 0);
    check("rst.bl_count", bl_count_o, 0);
    @(posedge clk); #2;
    reset_i = 1'b0;

    // Plain literals
    clear_pairs();
    for (int i = 1; i <= 5; i++) add(i, 0);
    run_vec("t1", 5);

    // Copy-previous run with in_ready held low across the repeat cycles
    clear_pairs();
    add(2, 0); add(16, 3); add(0, 0);
    run_model(8);
    do_start(8);
    send_pair(2, 0);
    send_pair(16, 3);
    ok = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (wr_en_o && !in_ready_o) ok++;
    end
    check("t2.repeat_busy", ok, 6);
    send_pair(0, 0);
    end_vec("t2");

    // Longest zero runs filling all but the last slot
    clear_pairs();
    add(18, 127); add(17, 7); add(4, 0);
    run_vec("t3", 149);

    // Copy with no previous length
    clear_pairs();
    add(16, 0); add(1, 0);
    run_vec("t4", 5);

    // Run overrunning num_syms
    clear_pairs();
    add(3, 0); add(17, 7);
    run_vec("t5", 10);

    // Illegal vector lengths
    clear_pairs();
    add(1, 0);
    run_vec("nzero", 0);
    run_vec("nbig", MAX_SYMS + 1);

    // Exactly MAX_SYMS with two long zero runs then literals
    clear_pairs();
    add(18, 127); add(18, 127); add(17, 7);
    for (int i = 0; i < 30; i++) add(i % 16, 0);
    run_vec("nmax", MAX_SYMS);

    // Restart while a run is in flight
    do_start(50);
    send_pair(18, 20);
    repeat (3) @(posedge clk);
    gen(40);
    run_vec("restart", 40);

    // Asynchronous reset in the middle of a run
    do_start(200);
    send_pair(18, 100);
    repeat (4) @(posedge clk);
    #2;
    check("t6.midrun_wr", wr_en_o, 1);
    reset_i = 1'b1;
    #1;
    check("t6.wr_en",    wr_en_o, 0);
    check("t6.in_ready", in_ready_o, 0);
    check("t6.done",     done_o, 0);
    @(posedge clk); #2;
    reset_i = 1'b0;
    gen(60);
    run_vec("t6.fresh", 60);

    // Random streams
    for (int t = 0; t < 14; t++) begin
      num = (t % 3 == 0) ? int'($urandom_range(1, 20)) : int'($urandom_range(1, MAX_SYMS));
      gen(num);
      run_vec($sformatf("rnd%0d", t), num);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
